// File: rtl/debounce_pkg.sv
// Shared widths, default parameters and named button indices for the
// push-button debouncer.
package debounce_pkg;

  localparam int CNT_W              = 4;
  localparam int N_BTN_DEF          = 5;
  localparam int STABLE_SAMPLES_DEF = 4;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level
// and registered one-cycle press/release pulses, advanced by the shared tick.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign differ = sync_q2 ^ btn_level;
  assign accept = tick & differ & (cnt == CNT_LAST);

  // Any sample matching the current level restarts the run; the counter
  // never passes CNT_LAST because acceptance clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= accept & sync_q2;
      btn_release <= accept & ~sync_q2;
      if (tick) begin
        if (!differ || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (accept) begin
          btn_level <= sync_q2;
        end
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: turns the slow clk_debounce square wave
// into a one-cycle sample tick and fans it out to per-button channels.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int N_BTN          = N_BTN_DEF,
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_debounce,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  logic s1;
  logic s2;
  logic s3;
  logic tick;

  // clk_debounce is treated purely as data: synchronize, then detect its rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_debounce;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized bench for button_debouncer against a sample-window reference model.
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int NB = 5;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_debounce = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  button_debouncer #(
    .N_BTN(NB),
    .STABLE_SAMPLES(S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_debounce(clk_debounce),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a rising slow clock seen at a clk edge samples the buttons
  // at that edge, and the result shows up two edges later. A level changes when
  // the last S samples since the previous change/reset all differ from it.
  typedef struct {
    int            due;
    logic [NB-1:0] smp;
  } pend_t;

  pend_t         pend_q[$];
  logic          hist[NB][$];
  logic [NB-1:0] m_level = '0;
  logic [NB-1:0] m_press = '0;
  logic [NB-1:0] m_rel = '0;
  logic          prev_cd = 1'b0;
  int            edge_no = 0;

  task automatic model_sample(input logic [NB-1:0] s);
    for (int ch = 0; ch < NB; ch++) begin
      bit all_diff;
      hist[ch].push_back(s[ch]);
      if (hist[ch].size() > S) void'(hist[ch].pop_front());
      all_diff = (hist[ch].size() == S);
      for (int k = 0; k < hist[ch].size(); k++)
        if (hist[ch][k] == m_level[ch]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[ch] = s[ch];
        if (s[ch]) m_press[ch] = 1'b1;
        else       m_rel[ch]   = 1'b1;
        hist[ch].delete();
      end
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      prev_cd = 1'b0;
      pend_q.delete();
      for (int ch = 0; ch < NB; ch++) hist[ch].delete();
    end else begin
      m_press = '0;
      m_rel   = '0;
      if (pend_q.size() > 0 && pend_q[0].due == edge_no) begin
        pend_t p;
        p = pend_q.pop_front();
        model_sample(p.smp);
      end
      if (clk_debounce && !prev_cd) pend_q.push_back('{edge_no + 2, btn_raw});
      prev_cd = clk_debounce;
    end
    edge_no++;
  endtask

  bit cd_run  = 1'b1;
  int cd_half = 10;
  int cd_cnt  = 0;
  int cnt_press[NB];
  int cnt_rel[NB];
  int n_press_all = 0;

  task automatic clear_counts();
    for (int ch = 0; ch < NB; ch++) begin
      cnt_press[ch] = 0;
      cnt_rel[ch]   = 0;
    end
    n_press_all = 0;
  endtask

  function automatic int sum_pulses(input int skip);
    int t = 0;
    for (int ch = 0; ch < NB; ch++)
      if (ch != skip) t += cnt_press[ch] + cnt_rel[ch];
    return t;
  endfunction

  // Inputs are driven 1 time unit after a rising edge; outputs are checked there too.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      if (cd_run) begin
        if (cd_cnt >= cd_half - 1) begin
          clk_debounce = ~clk_debounce;
          cd_cnt = 0;
        end else begin
          cd_cnt++;
        end
      end
      @(posedge clk);
      model_edge();
      #1;
      chk("level", 32'(btn_level), 32'(m_level));
      chk("press", 32'(btn_press), 32'(m_press));
      chk("release", 32'(btn_release), 32'(m_rel));
      for (int ch = 0; ch < NB; ch++) begin
        cnt_press[ch] += int'(btn_press[ch]);
        cnt_rel[ch]   += int'(btn_release[ch]);
      end
      if (btn_press == 5'h1f) n_press_all++;
    end
  endtask

  logic [NB-1:0] snap;

  initial begin
    clear_counts();

    // reset held with all buttons pressed and ticks running
    btn_raw = 5'h1f;
    run_cycles(60);
    chk("rst_level", 32'(btn_level), 32'h0);
    rst_n = 1'b1;
    clear_counts();
    run_cycles(120);
    chk("rst_press_all", 32'(n_press_all), 32'd1);
    chk("rst_level_all", 32'(btn_level), 32'h1f);

    btn_raw = '0;
    run_cycles(120);
    chk("all_released", 32'(btn_level), 32'h0);

    // clean press on one channel
    clear_counts();
    btn_raw[BTN_LEFT] = 1'b1;
    run_cycles(120);
    chk("press_level", 32'(btn_level), 32'h04);
    chk("press_pulses", 32'(cnt_press[BTN_LEFT]), 32'd1);
    chk("press_others", 32'(sum_pulses(BTN_LEFT)), 32'd0);

    // bounce: three ticks per level, never enough to accept
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      btn_raw[BTN_DOWN] = ~btn_raw[BTN_DOWN];
      run_cycles(60);
    end
    chk("bounce_level", 32'(btn_level[BTN_DOWN]), 32'd0);
    chk("bounce_pulses", 32'(cnt_press[BTN_DOWN] + cnt_rel[BTN_DOWN]), 32'd0);
    btn_raw[BTN_DOWN] = 1'b1;
    run_cycles(120);
    chk("bounce_accept", 32'(btn_level[BTN_DOWN]), 32'd1);
    chk("bounce_press", 32'(cnt_press[BTN_DOWN]), 32'd1);

    // release
    clear_counts();
    btn_raw[BTN_LEFT] = 1'b0;
    run_cycles(120);
    chk("release_level", 32'(btn_level[BTN_LEFT]), 32'd0);
    chk("release_pulse", 32'(cnt_rel[BTN_LEFT]), 32'd1);

    // reset in the middle of a count
    clear_counts();
    btn_raw[BTN_RIGHT] = 1'b1;
    run_cycles(60);
    rst_n = 1'b0;
    run_cycles(2);
    chk("midrst_level", 32'(btn_level), 32'h0);
    chk("midrst_pulses", 32'(sum_pulses(-1)), 32'd0);
    rst_n = 1'b1;
    run_cycles(120);
    chk("midrst_accept", 32'(btn_level[BTN_RIGHT]), 32'd1);

    // slow clock frozen low: buttons may do anything
    cd_run = 1'b0;
    clk_debounce = 1'b0;
    run_cycles(5);
    snap = m_level;
    clear_counts();
    for (int i = 0; i < 300; i++) begin
      btn_raw = NB'($urandom);
      run_cycles(1);
    end
    chk("freeze_level", 32'(btn_level), 32'(snap));
    chk("freeze_pulses", 32'(sum_pulses(-1)), 32'd0);

    // random traffic with varying slow-clock rate and occasional resets
    cd_run = 1'b1;
    cd_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) cd_half = int'($urandom_range(12, 2));
      for (int ch = 0; ch < NB; ch++)
        if ($urandom_range(39) == 0) btn_raw[ch] = ~btn_raw[ch];
      if ($urandom_range(799) == 0) begin
        rst_n = 1'b0;
        run_cycles(int'($urandom_range(3, 1)));
        rst_n = 1'b1;
      end
      run_cycles(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Multi-channel push-button debouncer and edge detector for the board's user buttons.
- Consumes the slow `clk_debounce` square wave from the clock generator (about 2 ms period from 100 MHz) as a sampling strobe.
- Runs entirely in the 100 MHz `clk` domain.
- Produces clean button levels plus one-cycle press/release pulses for the game control FSM.

Parameters:
- N_BTN, 5, number of independent button channels.
- STABLE_SAMPLES, 4, consecutive equal samples required to accept a new level (legal range 2..15).

Ports:
- clk  input  1  100 MHz system clock.
- rst_n  input  1  asynchronous active-low reset.
- clk_debounce  input  1  slow sampling square wave from the clock generator; asynchronous to the logic, used only as data.
- btn_raw  input  N_BTN  raw, bouncy, asynchronous button inputs, active high.
- btn_level  output  N_BTN  debounced button level.
- btn_press  output  N_BTN  one-clk pulse on an accepted 0->1 transition.
- btn_release  output  N_BTN  one-clk pulse on an accepted 1->0 transition.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ports `clk`, `rst_n`).
  - While `rst_n`=0, all synchronizer flops, counters, `btn_level`, `btn_press` and `btn_release` are 0.
  - Asserting reset mid-count or mid-pulse clears everything immediately. No pulse is emitted on reset entry or exit.
- Synchronization:
  - `clk_debounce` passes through two flops (s1, s2) plus a history flop (s3).
  - Each `btn_raw` bit passes through its own two-flop synchronizer.
- Sample tick: tick = s2 & ~s3, high for exactly one clk cycle per `clk_debounce` rising edge.
  - Latency from the `clk_debounce` rise to the state update is 3 clk edges.
  - If `clk_debounce` is high at reset release, one tick occurs within 3 cycles. This is legal.
- Per-channel counter `cnt`: width 4 bits. State updates only on tick cycles; between ticks everything holds.
  - If synced sample == btn_level: cnt <= 0.
  - If sample != btn_level and cnt < STABLE_SAMPLES-1: cnt <= cnt+1.
  - If sample != btn_level and cnt == STABLE_SAMPLES-1: btn_level <= sample, cnt <= 0. Assert btn_press (if sample=1) or btn_release (if sample=0) on the same edge.
- Pulses:
  - `btn_press` and `btn_release` are registered. They are high for exactly one clk cycle and cleared the next cycle.
  - They are never both high on one channel.
- Bounce rejection: any sample equal to the current level restarts the count. A level change therefore needs STABLE_SAMPLES consecutive differing ticks (about 8 ms by default).
- Channel independence: channels are independent. Several channels may pulse in the same cycle.
- Counter saturation: `cnt` never exceeds STABLE_SAMPLES-1, so there is no wrap-around.
- Button timing vs. tick: a `btn_raw` change within 2 cycles before a tick is sampled at the following tick.

Decomposition:
- Package `debounce_pkg`:
  - CNT_W = 4.
  - Default N_BTN and STABLE_SAMPLES.
  - Named button indices: BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER.
- Sub-module `debounce_channel`: one per button, generated N_BTN times.
  - Contains the 2-flop synchronizer, counter, level register and pulse registers.
  - Takes the shared tick as input.
- Top level: the `clk_debounce` synchronizer/edge detector plus the generate loop.

Test Plan (STABLE_SAMPLES=4; bench toggles `clk_debounce` every 10 clk cycles to shorten the run):
- Reset: hold rst_n=0 with btn_raw=5'b11111 and ticks running -> all outputs 0. Release -> btn_level[0] rises 3 clk edges after the 4th post-reset `clk_debounce` rise; all 5 `btn_press` bits pulse in the same single cycle.
- Clean press: btn_raw[2] 0->1 held -> btn_press[2]=1 for exactly 1 cycle, coincident with btn_level[2] rising, 3 clk after the 4th tick rise. Nothing on other channels.
- Bounce: btn_raw[1] alternates level every 3 ticks for 30 ticks -> btn_level[1] stays 0, no pulses. Then held at 1 -> press accepted on the 4th stable tick.
- Release: after an accepted press, drive btn_raw[2]=0 -> btn_release[2] one-cycle pulse after 4 ticks; btn_level[2] falls on the same edge.
- Reset mid-count: btn_raw[3]=1 for 3 ticks, then rst_n=0 for 2 cycles -> btn_level[3]=0 and no pulse. After release, 4 further ticks are needed before the press is accepted.
- Slow clock frozen: hold clk_debounce at 0 and toggle btn_raw freely -> outputs never change.
